// File: rtl/qu_rob.sv
`default_nettype none
// ============================================================================
// Module   : qu_rob
// Purpose  : Reorder buffer. Dispatch allocates entries at the tail, issue and
//            writeback advance each entry through its lifecycle, and completed
//            entries commit to the physical register file strictly in
//            allocation order from the head.
// Ports    : clk, rst                          - clock, sync active-high reset
//            alloc_valid_i/dest_i/ready_o/addr_o - dispatch allocation
//            issue_valid_i/addr_i              - entry issued to a unit
//            wb_valid_i/addr_i/value_i         - execution result broadcast
//            rd_addr_i/rd_value_o/rd_ready_o   - operand lookup
//            commit_valid_o/dest_o/value_o, commit_ready_i - in-order retire
//            flush_i                           - discard all entries
//            count_o/full_o/empty_o            - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module qu_rob #(
  parameter int ROB_DEPTH         = 8,
  parameter int PHY_RF_ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid_i,
  input  logic [PHY_RF_ADDR_WIDTH-1:0]  alloc_dest_i,
  output logic                          alloc_ready_o,
  output logic [$clog2(ROB_DEPTH)-1:0]  alloc_addr_o,
  input  logic                          issue_valid_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]  issue_addr_i,
  input  logic                          wb_valid_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]  wb_addr_i,
  input  logic [31:0]                   wb_value_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]  rd_addr_i,
  output logic [31:0]                   rd_value_o,
  output logic                          rd_ready_o,
  output logic                          commit_valid_o,
  output logic [PHY_RF_ADDR_WIDTH-1:0]  commit_dest_o,
  output logic [31:0]                   commit_value_o,
  input  logic                          commit_ready_i,
  input  logic                          flush_i,
  output logic [$clog2(ROB_DEPTH):0]    count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(ROB_DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_RETIRED = 2'b01;
  localparam logic [1:0] ST_EXECUTE = 2'b10;
  localparam logic [1:0] ST_PENDING = 2'b11;

  logic [1:0]                   state_q [ROB_DEPTH];
  logic [1:0]                   state_d [ROB_DEPTH];
  logic [31:0]                  value_q [ROB_DEPTH];
  logic [31:0]                  value_d [ROB_DEPTH];
  logic [PHY_RF_ADDR_WIDTH-1:0] dest_q  [ROB_DEPTH];
  logic [PHY_RF_ADDR_WIDTH-1:0] dest_d  [ROB_DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic alloc_fire;
  logic commit_fire;

  // Status and lookup outputs come straight from registered state, so a
  // writeback in the current cycle is only visible from the next cycle.
  assign full_o         = (count_q == (AW+1)'(ROB_DEPTH));
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;
  assign alloc_ready_o  = !full_o;
  assign alloc_addr_o   = tail_q;
  assign commit_valid_o = (state_q[head_q] == ST_RETIRED) && !flush_i;
  assign commit_dest_o  = dest_q[head_q];
  assign commit_value_o = value_q[head_q];
  assign rd_value_o     = value_q[rd_addr_i];
  assign rd_ready_o     = (state_q[rd_addr_i] == ST_RETIRED);

  assign alloc_fire  = alloc_valid_i && alloc_ready_o && !flush_i;
  assign commit_fire = commit_valid_o && commit_ready_i;

  // Per-entry next state. Writeback outranks issue so that a same-cycle
  // issue+writeback lands in RETIRED. Commit only targets a RETIRED head and
  // allocation only targets an EMPTY tail, so neither can collide with a
  // legal issue/writeback on the same entry.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      state_d[i] = state_q[i];
      value_d[i] = value_q[i];
      dest_d[i]  = dest_q[i];
      if (wb_valid_i && (wb_addr_i == AW'(i)) &&
          ((state_q[i] == ST_PENDING) || (state_q[i] == ST_EXECUTE))) begin
        state_d[i] = ST_RETIRED;
        value_d[i] = wb_value_i;
      end else if (issue_valid_i && (issue_addr_i == AW'(i)) &&
                   (state_q[i] == ST_PENDING)) begin
        state_d[i] = ST_EXECUTE;
      end
      if (commit_fire && (head_q == AW'(i))) begin
        state_d[i] = ST_EMPTY;
      end
      if (alloc_fire && (tail_q == AW'(i))) begin
        state_d[i] = ST_PENDING;
        dest_d[i]  = alloc_dest_i;
        value_d[i] = '0;
      end
      if (flush_i) begin
        state_d[i] = ST_EMPTY;
      end
    end
  end

  // Pointers wrap naturally because ROB_DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) begin
        head_d = head_q + AW'(1);
      end
      if (alloc_fire) begin
        tail_d = tail_q + AW'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
        value_q[i] <= '0;
        dest_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        value_q[i] <= value_d[i];
        dest_q[i]  <= dest_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qu_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_qu_rob
// Purpose  : Self-checking bench for qu_rob. A queue-based reference model
//            (live entries in allocation order plus per-index records) predicts
//            every output; directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qu_rob;

  localparam int DEPTH = 8;
  localparam int DW    = 7;

  localparam int M_EMPTY   = 0;
  localparam int M_RETIRED = 1;
  localparam int M_EXECUTE = 2;
  localparam int M_PENDING = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid_i = 1'b0;
  logic [DW-1:0] alloc_dest_i = '0;
  logic          alloc_ready_o;
  logic [2:0]    alloc_addr_o;
  logic          issue_valid_i = 1'b0;
  logic [2:0]    issue_addr_i = '0;
  logic          wb_valid_i = 1'b0;
  logic [2:0]    wb_addr_i = '0;
  logic [31:0]   wb_value_i = '0;
  logic [2:0]    rd_addr_i = '0;
  logic [31:0]   rd_value_o;
  logic          rd_ready_o;
  logic          commit_valid_o;
  logic [DW-1:0] commit_dest_o;
  logic [31:0]   commit_value_o;
  logic          commit_ready_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [3:0]    count_o;
  logic          full_o;
  logic          empty_o;

  qu_rob #(.ROB_DEPTH(DEPTH), .PHY_RF_ADDR_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_dest_i   (alloc_dest_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_addr_o   (alloc_addr_o),
    .issue_valid_i  (issue_valid_i),
    .issue_addr_i   (issue_addr_i),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .wb_value_i     (wb_value_i),
    .rd_addr_i      (rd_addr_i),
    .rd_value_o     (rd_value_o),
    .rd_ready_o     (rd_ready_o),
    .commit_valid_o (commit_valid_o),
    .commit_dest_o  (commit_dest_o),
    .commit_value_o (commit_value_o),
    .commit_ready_i (commit_ready_i),
    .flush_i        (flush_i),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: live holds entry indices oldest-first.
  int          m_st   [DEPTH];
  logic [31:0] m_val  [DEPTH];
  logic [DW-1:0] m_dest [DEPTH];
  int          live[$];
  int          m_tail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i]   = M_EMPTY;
      m_val[i]  = '0;
      m_dest[i] = '0;
    end
    live.delete();
    m_tail = 0;
  endtask

  function automatic bit model_cv();
    return (live.size() > 0) && (m_st[live[0]] == M_RETIRED) && !flush_i;
  endfunction

  // Drive one cycle's inputs on the falling edge and compare all outputs.
  task automatic drive(input logic a_v, input logic [DW-1:0] a_d,
                       input logic i_v, input logic [2:0] i_a,
                       input logic w_v, input logic [2:0] w_a, input logic [31:0] w_d,
                       input logic c_r, input logic fl, input logic r,
                       input logic [2:0] rd);
    bit cv;
    bit rdy;
    @(negedge clk);
    alloc_valid_i = a_v; alloc_dest_i = a_d;
    issue_valid_i = i_v; issue_addr_i = i_a;
    wb_valid_i = w_v; wb_addr_i = w_a; wb_value_i = w_d;
    commit_ready_i = c_r; flush_i = fl; rst = r; rd_addr_i = rd;
    #1;
    chk("alloc_ready", alloc_ready_o, live.size() != DEPTH);
    chk("alloc_addr", alloc_addr_o, m_tail);
    chk("count", count_o, live.size());
    chk("full", full_o, live.size() == DEPTH);
    chk("empty", empty_o, live.size() == 0);
    cv = model_cv();
    chk("commit_valid", commit_valid_o, cv);
    if (cv) begin
      chk("commit_dest", commit_dest_o, m_dest[live[0]]);
      chk("commit_value", commit_value_o, m_val[live[0]]);
    end
    rdy = (m_st[rd] == M_RETIRED);
    chk("rd_ready", rd_ready_o, rdy);
    if (rdy) chk("rd_value", rd_value_o, m_val[rd]);
  endtask

  // Clock edge: apply the held inputs to the model.
  task automatic advance();
    bit cv;
    int wa;
    int ia;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) m_st[i] = M_EMPTY;
      live.delete();
      m_tail = 0;
    end else begin
      cv = model_cv();
      wa = int'(wb_addr_i);
      ia = int'(issue_addr_i);
      if (wb_valid_i && (m_st[wa] == M_PENDING || m_st[wa] == M_EXECUTE)) begin
        m_st[wa]  = M_RETIRED;
        m_val[wa] = wb_value_i;
        if (issue_valid_i && ia != wa && m_st[ia] == M_PENDING) m_st[ia] = M_EXECUTE;
      end else if (issue_valid_i && m_st[ia] == M_PENDING) begin
        m_st[ia] = M_EXECUTE;
      end
      if (alloc_valid_i && live.size() < DEPTH) begin
        m_st[m_tail]   = M_PENDING;
        m_dest[m_tail] = alloc_dest_i;
        m_val[m_tail]  = '0;
        live.push_back(m_tail);
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (cv && commit_ready_i) begin
        m_st[live[0]] = M_EMPTY;
        void'(live.pop_front());
      end
    end
  endtask

  task automatic idle(input logic [2:0] rd);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    advance();
  endtask

  task automatic alloc(input logic [DW-1:0] d);
    drive(1, d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic wb(input logic [2:0] a, input logic [31:0] v);
    drive(0, 0, 0, 0, 1, a, v, 0, 0, 0, a);
    advance();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    idle(0);
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_rd_ready", rd_ready_o, 0);
    advance();

    // Single entry lifecycle
    alloc(7'd5);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); advance();
    wb(0, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t34_cv", commit_valid_o, 1);
    chk("t34_dest", commit_dest_o, 5);
    chk("t34_value", commit_value_o, 32'hDEADBEEF);
    advance();
    idle(0);
    chk("t34_empty", empty_o, 1);
    advance();

    // Fill to capacity, overflow dropped, commit+alloc when full
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(7'(20 + i));
    drive(1, 7'd99, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t35_full", full_o, 1);
    chk("t35_ready", alloc_ready_o, 0);
    chk("t35_count", count_o, 8);
    advance();
    idle(0);
    chk("t35_tail", alloc_addr_o, 0);
    advance();
    wb(0, 32'h1234);
    drive(1, 7'd77, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t37_count", count_o, 8);
    chk("t37_ready", alloc_ready_o, 0);
    advance();
    idle(0);
    chk("t37_after", count_o, 7);
    advance();

    // Out-of-order completion, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) alloc(7'(10 + i));
    wb(2, 32'h22);
    wb(1, 32'h11);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t36_blocked", commit_valid_o, 0);
    advance();
    wb(0, 32'h00);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t36_order", commit_dest_o, 10 + i);
      advance();
    end

    // Flush with a pending commit
    do_reset();
    for (int i = 0; i < 5; i++) alloc(7'(40 + i));
    wb(0, 32'hAA);
    wb(3, 32'hBB);
    drive(1, 7'd1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("t38_cv", commit_valid_o, 0);
    advance();
    for (int i = 0; i < DEPTH; i++) begin
      idle(3'(i));
      chk("t38_rd_ready", rd_ready_o, 0);
      advance();
    end
    idle(0);
    chk("t38_count", count_o, 0);
    chk("t38_addr", alloc_addr_o, 0);
    advance();

    // Dense alloc/writeback/commit loop forcing pointer wrap
    for (int c = 0; c < 20; c++) begin
      logic [2:0] wa;
      wa = (live.size() > 0) ? 3'(live[0]) : 3'd0;
      drive(1, 7'($urandom), 0, 0, live.size() > 0, wa, $urandom, 1, 0, 0, wa);
      advance();
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] wa, ia;
      wa = 3'($urandom);
      ia = 3'($urandom);
      if (live.size() > 0 && $urandom_range(0, 1) == 1) wa = 3'(live[$urandom_range(0, live.size() - 1)]);
      if (live.size() > 0 && $urandom_range(0, 1) == 1) ia = 3'(live[$urandom_range(0, live.size() - 1)]);
      drive($urandom_range(0, 9) < 6, 7'($urandom),
            $urandom_range(0, 9) < 4, ia,
            $urandom_range(0, 9) < 4, wa, $urandom,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 199) < 1,
            3'($urandom));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
